cache_controller: RTL
=====================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter LOG_NUM_LINES, default 2: log2 of the number of cache lines.
REQ-002 SHALL have parameter LOG_NUM_BLOCKS, default 1: log2 of the words per line.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: word width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8: word address width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have CPU-side ports:
- cpu_req, input, 1 bit: request strobe.
- cpu_we, input, 1 bit: 1 = write, 0 = read.
- cpu_addr, input, ADDR_WIDTH bits: request address.
- cpu_wdata, input, DATA_WIDTH bits: write data.
- cpu_ready, output, 1 bit: one-cycle completion pulse.
- cpu_rdata, output, DATA_WIDTH bits: read data.
- cpu_busy, output, 1 bit: high when the state is not IDLE.
REQ-008 SHALL have cache-side ports:
- cache_write_en, output, 1 bit.
- cache_write_data, output, DATA_WIDTH bits.
- cache_address, output, ADDR_WIDTH bits.
- cache_hit, input, 1 bit.
- cache_read_data, input, DATA_WIDTH bits.
- The cache read path is combinational with respect to cache_address.
REQ-009 SHALL have memory-side ports:
- mem_req, output, 1 bit.
- mem_we, output, 1 bit.
- mem_addr, output, ADDR_WIDTH bits.
- mem_wdata, output, DATA_WIDTH bits.
- mem_ack, input, 1 bit.
- mem_rdata, input, DATA_WIDTH bits.
REQ-010 SHALL have statistics outputs read_hits and read_misses, output, 16 bits each.

Function
REQ-011 SHALL implement states IDLE, LOOKUP, FILL, WMEM and RESP.
REQ-012 In IDLE, SHALL latch cpu_we, cpu_addr and cpu_wdata when cpu_req=1, then go to LOOKUP; cpu_req SHALL be ignored in every other state.
REQ-013 SHALL drive cache_address from the latched address in every state except FILL.
REQ-014 SHALL drive cache_write_data from the latched wdata in every state except FILL.
REQ-015 In LOOKUP, read with cache_hit=1: SHALL capture cache_read_data into cpu_rdata, increment read_hits, and go to RESP.
REQ-016 In LOOKUP, read with cache_hit=0: SHALL increment read_misses, clear the word counter, and go to FILL.
REQ-017 In LOOKUP, write: SHALL assert cache_write_en for that cycle only if cache_hit=1 (write-through, no-write-allocate), then go to WMEM.
REQ-018 In FILL, SHALL hold mem_req=1, mem_we=0 and mem_addr={latched tag, latched index, counter} stable until mem_ack=1.
REQ-019 In FILL, SHALL drive cache_address equal to mem_addr and cache_write_data equal to mem_rdata.
REQ-020 On each FILL cycle with mem_ack=1:
- SHALL assert cache_write_en.
- SHALL capture mem_rdata into cpu_rdata when counter equals the latched block offset.
- SHALL increment the counter.
- After word NUM_BLOCKS-1, SHALL go to RESP; otherwise the next word SHALL be requested in the next cycle.
REQ-021 In WMEM, SHALL hold mem_req=1, mem_we=1, mem_addr=latched address and mem_wdata=latched wdata until mem_ack=1, then go to RESP.
REQ-022 In RESP, SHALL assert cpu_ready for exactly one cycle, hold cpu_rdata valid, and return to IDLE.
REQ-023 A new cpu_req SHALL be accepted no earlier than the cycle after RESP.
REQ-024 Read-hit latency SHALL be fixed: request seen in IDLE at cycle 0, LOOKUP at cycle 1, cpu_ready at cycle 2.
REQ-025 Miss and write latency SHALL be 2 cycles plus all mem_ack wait cycles.
REQ-026 mem_ack SHALL be ignored whenever mem_req=0.
REQ-027 read_hits and read_misses SHALL saturate at 0xFFFF and not wrap.
REQ-028 cache_write_en SHALL be 0 in IDLE, WMEM and RESP.

Reset
REQ-029 With rst=1 at a clock edge, SHALL enter IDLE and clear the counter, read_hits and read_misses.
REQ-030 During reset, SHALL drive cpu_ready=0, cpu_busy=0, cpu_rdata=0, mem_req=0, mem_we=0 and cache_write_en=0.
REQ-031 Reset SHALL have priority over all other events, including a mid-FILL or mid-WMEM reset concurrent with mem_ack=1; no cache write SHALL occur in that cycle.

Verification
REQ-032 After reset, read 0x14 with memory returning 0xAAAA0014 for 0x14 and 0xAAAA0015 for 0x15:
- SHALL issue mem reads 0x14 then 0x15.
- SHALL pulse cpu_ready with cpu_rdata=0xAAAA0014.
- SHALL give read_misses=1.
REQ-033 A following read of 0x15:
- SHALL produce no mem_req.
- SHALL give cpu_ready at cycle 2 with 0xAAAA0015.
- SHALL give read_hits=1.
REQ-034 Write 0x15 with data 0xDEADBEEF:
- SHALL assert cache_write_en in LOOKUP.
- SHALL issue a mem write to 0x15.
- A later read of 0x15 SHALL hit and return 0xDEADBEEF.
REQ-035 Write miss to 0x40:
- SHALL issue a mem write only, with no cache_write_en.
- A later read of 0x40 SHALL miss and fill 0x40, 0x41.
REQ-036 With mem_ack delayed 5 cycles, mem_req and mem_addr SHALL stay stable for all 5 cycles.
REQ-037 Reset asserted in FILL after word 0 SHALL give mem_req=0 next cycle and the state IDLE.
REQ-038 Conflict test, read 0x14, then 0x34 (same index 2), then 0x14: all three SHALL miss and refill, giving read_misses=3.

Source files
------------

// File: rtl/cache_controller.sv
// ----------------------------------------------------------------------------
// cache_controller
//   Write-through, no-write-allocate controller sitting between a CPU port,
//   an external direct-mapped cache array (tag compare done outside) and a
//   word-wide main memory. Read misses fill the whole line word by word.
//
// Ports
//   clk, rst                  : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata     : CPU request, latched in IDLE
//   cpu_ready/rdata/busy      : one-cycle completion pulse, read data, busy
//   cache_write_en/write_data/address : cache array write/read port
//   cache_hit, cache_read_data: combinational lookup result for cache_address
//   mem_req/we/addr/wdata     : memory request, held until mem_ack
//   mem_ack, mem_rdata        : memory completion and read data
//   read_hits, read_misses    : saturating read statistics
// ----------------------------------------------------------------------------
module cache_controller #(
   parameter int LOG_NUM_LINES  = 2,
   parameter int LOG_NUM_BLOCKS = 1,
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ready,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_busy,
   output logic                  cache_write_en,
   output logic [DATA_WIDTH-1:0] cache_write_data,
   output logic [ADDR_WIDTH-1:0] cache_address,
   input  logic                  cache_hit,
   input  logic [DATA_WIDTH-1:0] cache_read_data,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [15:0]           read_hits,
   output logic [15:0]           read_misses
);

   localparam int TAG_W = ADDR_WIDTH - LOG_NUM_LINES - LOG_NUM_BLOCKS;

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WMEM, RESP} state_t;

   state_t                    r_state, w_next;
   logic                      r_we;
   logic [ADDR_WIDTH-1:0]     r_addr;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic [DATA_WIDTH-1:0]     r_rdata;
   logic [LOG_NUM_BLOCKS-1:0] r_cnt;
   logic [15:0]               r_hits;
   logic [15:0]               r_misses;

   logic [TAG_W-1:0]          w_tag;
   logic [LOG_NUM_LINES-1:0]  w_index;
   logic [LOG_NUM_BLOCKS-1:0] w_offset;
   logic [ADDR_WIDTH-1:0]     w_fill_addr;
   logic                      w_last;

   assign w_tag       = r_addr[ADDR_WIDTH-1 -: TAG_W];
   assign w_index     = r_addr[LOG_NUM_BLOCKS +: LOG_NUM_LINES];
   assign w_offset    = r_addr[LOG_NUM_BLOCKS-1:0];
   // Line fill walks every word of the line, starting from word 0
   assign w_fill_addr = {w_tag, w_index, r_cnt};
   assign w_last      = (r_cnt == '1);

   // Reset forces the visible outputs low even before the state register
   // has been cleared, so a reset cycle can never write the cache.
   assign cpu_rdata   = rst ? '0 : r_rdata;
   assign read_hits   = r_hits;
   assign read_misses = r_misses;

   always_comb begin
      w_next           = r_state;
      cpu_ready        = 1'b0;
      cpu_busy         = (r_state != IDLE);
      cache_write_en   = 1'b0;
      cache_address    = r_addr;
      cache_write_data = r_wdata;
      mem_req          = 1'b0;
      mem_we           = 1'b0;
      mem_addr         = r_addr;
      mem_wdata        = r_wdata;
      case (r_state)
         IDLE:   if (cpu_req) w_next = LOOKUP;
         LOOKUP: begin
            if (r_we) begin
               // write-through; only update the array when the line is present
               cache_write_en = cache_hit;
               w_next         = WMEM;
            end else begin
               w_next = cache_hit ? RESP : FILL;
            end
         end
         FILL: begin
            mem_req          = 1'b1;
            mem_addr         = w_fill_addr;
            cache_address    = w_fill_addr;
            cache_write_data = mem_rdata;
            if (mem_ack) begin
               cache_write_en = 1'b1;
               if (w_last) w_next = RESP;
            end
         end
         WMEM: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) w_next = RESP;
         end
         RESP: begin
            cpu_ready = 1'b1;
            w_next    = IDLE;
         end
         default: w_next = IDLE;
      endcase
      if (rst) begin
         w_next         = IDLE;
         cpu_ready      = 1'b0;
         cpu_busy       = 1'b0;
         cache_write_en = 1'b0;
         mem_req        = 1'b0;
         mem_we         = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rdata  <= '0;
         r_cnt    <= '0;
         r_hits   <= '0;
         r_misses <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: if (cpu_req) begin
               r_we    <= cpu_we;
               r_addr  <= cpu_addr;
               r_wdata <= cpu_wdata;
            end
            LOOKUP: if (!r_we) begin
               if (cache_hit) begin
                  r_rdata <= cache_read_data;
                  if (r_hits != 16'hFFFF) r_hits <= r_hits + 16'd1;
               end else begin
                  r_cnt <= '0;
                  if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
               end
            end
            FILL: if (mem_ack) begin
               // the requested word is forwarded as it streams past
               if (r_cnt == w_offset) r_rdata <= mem_rdata;
               r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
